// File: rtl/dm_store_buffer.sv
// Store buffer between MEM and data memory. It decodes SW/SH/SB into a word
// address, lane-aligned write data and byte enables, and queues legal stores in
// a small FIFO. The head entry is offered to DM through a req/ack handshake.
// A misaligned store or an illegal op is never queued; it raises a one-cycle
// st_exc pulse instead.
module dm_store_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [2:0]       st_op,
  output logic             st_ready,
  output logic             st_exc,
  output logic             dm_req,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_wdata,
  output logic [3:0]       dm_be,
  input  logic             dm_ack,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } sb_entry_t;

  sb_entry_t        mem [DEPTH];
  sb_entry_t        head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             legal, accept, push, pop, full;
  logic [3:0]       be_n;
  logic [31:0]      wdata_n;
  logic [1:0]       a;

  assign a = st_addr[1:0];

  // Decode the store into byte enables and replicated lane data; flag bad ones.
  always_comb begin
    legal   = 1'b0;
    be_n    = 4'h0;
    wdata_n = st_data;
    case (st_op)
      3'b000: begin
        legal   = (a == 2'b00);
        be_n    = 4'hf;
        wdata_n = st_data;
      end
      3'b001: begin
        legal   = ~a[0];
        be_n    = a[1] ? 4'hc : 4'h3;
        wdata_n = {2{st_data[15:0]}};
      end
      3'b010: begin
        legal   = 1'b1;
        be_n    = 4'b0001 << a;
        wdata_n = {4{st_data[7:0]}};
      end
      default: legal = 1'b0;
    endcase
  end

  // Ready depends only on the registered count, so a same-cycle pop never
  // lets a push into a full buffer; ready rises the cycle after the pop.
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign st_ready = ~full;
  assign accept   = st_valid & st_ready;
  assign push     = accept & legal;
  assign pop      = dm_req & dm_ack;

  assign head     = mem[rd_ptr];
  assign dm_req   = ~empty;
  assign dm_addr  = {head.waddr, 2'b00};
  assign dm_wdata = head.wdata;
  assign dm_be    = head.be;

  // Entry storage is never cleared; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{waddr: st_addr[31:2], wdata: wdata_n, be: be_n};
  end

  // Pointers, occupancy and the exception pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      st_exc <= 1'b0;
    end else begin
      st_exc <= accept & ~legal;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_store_buffer.sv
// Self-checking bench for dm_store_buffer: directed scenarios followed by random
// traffic, all checked against a queue-based model of the store buffer.
module tb_dm_store_buffer;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             st_valid = 1'b0;
  logic [31:0]      st_addr = '0;
  logic [31:0]      st_data = '0;
  logic [2:0]       st_op = '0;
  logic             st_ready, st_exc, dm_req, empty;
  logic [31:0]      dm_addr, dm_wdata;
  logic [3:0]       dm_be;
  logic             dm_ack = 1'b0;
  logic [CNT_W-1:0] count;

  dm_store_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_addr(st_addr),
    .st_data(st_data), .st_op(st_op), .st_ready(st_ready), .st_exc(st_exc),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_ack(dm_ack), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t q[$];
  logic exc_exp = 1'b0;
  int   errs = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("st_ready", 32'(st_ready), 32'(q.size() < DEPTH));
    chk("dm_req", 32'(dm_req), 32'(q.size() != 0));
    chk("st_exc", 32'(st_exc), 32'(exc_exp));
    if (q.size() != 0) begin
      chk("dm_addr", dm_addr, q[0].addr);
      chk("dm_wdata", dm_wdata, q[0].wdata);
      chk("dm_be", 32'(dm_be), 32'(q[0].be));
    end
  endtask

  // Drive one cycle of inputs, advance the model to the post-edge state,
  // then compare the DUT just after the edge.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] op, input logic ack);
    int   sz;
    logic lg, acc, pp;
    exp_t e;
    @(negedge clk);
    reset = 1'b0; st_valid = v; st_addr = a; st_data = d; st_op = op; dm_ack = ack;
    sz  = (op == 3'd0) ? 4 : (op == 3'd1) ? 2 : (op == 3'd2) ? 1 : 0;
    lg  = (sz != 0) && ((a % sz) == 0);
    acc = v && (q.size() < DEPTH);
    pp  = ack && (q.size() != 0);
    e.addr  = a & 32'hffff_fffc;
    e.be    = 4'(((1 << sz) - 1) << (a % 4));
    e.wdata = (op == 3'd0) ? d : (op == 3'd1) ? d[15:0] * 32'h0001_0001
                                              : d[7:0] * 32'h0101_0101;
    exc_exp = acc && !lg;
    if (pp) void'(q.pop_front());
    if (acc && lg) q.push_back(e);
    @(posedge clk); #1;
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; st_valid = 1'b0; dm_ack = 1'b0;
    q.delete();
    exc_exp = 1'b0;
    @(posedge clk); #1;
    check_outputs();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    do_reset();

    // 1: single SW drains immediately
    step(1, 32'h10, 32'h1234_5678, 3'd0, 1);
    chk("t1_req", 32'(dm_req), 1);
    chk("t1_addr", dm_addr, 32'h10);
    chk("t1_be", 32'(dm_be), 32'hf);
    chk("t1_wdata", dm_wdata, 32'h1234_5678);
    step(0, 0, 0, 3'd0, 1);
    chk("t1_empty", 32'(empty), 1);

    // 2: SB and SH lane alignment
    step(1, 32'h13, 32'h0000_00ab, 3'd2, 0);
    chk("t2_sb_be", 32'(dm_be), 32'h8);
    chk("t2_sb_wdata", dm_wdata, 32'habab_abab);
    chk("t2_sb_addr", dm_addr, 32'h10);
    step(1, 32'h22, 32'h0000_beef, 3'd1, 1);
    chk("t2_sh_be", 32'(dm_be), 32'hc);
    chk("t2_sh_wdata", dm_wdata, 32'hbeef_beef);
    chk("t2_sh_addr", dm_addr, 32'h20);
    step(0, 0, 0, 3'd0, 1);

    // 3: misaligned stores pulse st_exc and queue nothing
    step(1, 32'h6, 32'h1, 3'd0, 1);
    chk("t3_exc_sw", 32'(st_exc), 1);
    chk("t3_cnt_sw", 32'(count), 0);
    step(1, 32'h3, 32'h1, 3'd1, 1);
    chk("t3_exc_sh", 32'(st_exc), 1);
    chk("t3_req", 32'(dm_req), 0);
    step(0, 0, 0, 3'd0, 1);
    chk("t3_exc_drop", 32'(st_exc), 0);

    // 4/5: fill, stall, pop-only when full, then refill and drain in order
    for (int i = 0; i < DEPTH; i++) step(1, 32'h100 + i, 32'(i + 1), 3'd2, 0);
    chk("t4_full_cnt", 32'(count), DEPTH);
    chk("t4_full_rdy", 32'(st_ready), 0);
    step(1, 32'h200, 32'h55, 3'd2, 0);
    chk("t4_stall_cnt", 32'(count), DEPTH);
    step(1, 32'h200, 32'h55, 3'd2, 1);
    chk("t5_pop_only", 32'(count), DEPTH - 1);
    chk("t5_rdy_back", 32'(st_ready), 1);
    step(1, 32'h200, 32'h55, 3'd2, 0);
    chk("t5_push_next", 32'(count), DEPTH);
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 3'd0, 1);
    step(1, 32'h40, 32'h7, 3'd0, 0);
    step(1, 32'h44, 32'h8, 3'd0, 1);
    chk("t5_pushpop_cnt", 32'(count), 1);
    step(0, 0, 0, 3'd0, 1);

    // 6: reset mid-drain discards queued stores
    step(1, 32'h80, 32'haaaa_aaaa, 3'd0, 0);
    step(1, 32'h84, 32'hbbbb_bbbb, 3'd0, 0);
    step(1, 32'h7, 32'h0, 3'd0, 1);
    do_reset();
    chk("t6_cnt", 32'(count), 0);
    chk("t6_req", 32'(dm_req), 0);
    chk("t6_exc", 32'(st_exc), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 3'd0, 1);

    // Random traffic, mostly legal ops with some illegal encodings
    for (int n = 0; n < 600; n++) begin
      int unsigned r;
      logic [2:0]  op;
      r  = $urandom_range(0, 9);
      op = (r < 9) ? 3'(r % 3) : 3'($urandom_range(3, 7));
      if (n == 300) do_reset();
      step(1'($urandom_range(0, 99) < 60), $urandom, $urandom, op,
           1'($urandom_range(0, 99) < 45));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
